// File: rtl/dilithium_pkg.sv
// Shared types and constants for the SHAKE256 core arbiter and its requesters.
package dilithium_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // Requester slots on the shared SHAKE256 core
  localparam int REQ_EXPANDA      = 0;
  localparam int REQ_EXPANDS      = 1;
  localparam int REQ_EXPANDMASK   = 2;
  localparam int REQ_SAMPLEINBALL = 3;
  localparam int NUM_SAMPLERS     = 4;

  // Modular add for ring indices; base and off are both below n
  function automatic int wrap_add(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/shake_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after the pointer, wrapping.
module rr_pick
  import dilithium_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             any
);

  // Scan the request ring starting at the pointer; first hit wins
  always_comb begin
    logic [IDX_W-1:0] cand;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDX_W'(wrap_add(int'(rr_ptr), k, NREQ));
      if (!any && req[cand]) begin
        any          = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE256 core among NREQ samplers. Round-robin grant held for a
// whole transaction; each new grant gets a one-cycle core flush before the
// owner's stream is connected.
module shake_arbiter
  import dilithium_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  output logic [NREQ-1:0]              grant,
  input  logic [NREQ-1:0]              r_force_reset,
  input  logic [NREQ*DATA_IN_BITS-1:0] r_data_in,
  input  logic [NREQ-1:0]              r_in_valid,
  input  logic [NREQ-1:0]              r_in_last,
  input  logic [NREQ*LEN_W-1:0]        r_last_len,
  input  logic [NREQ-1:0]              r_out_ready,
  output logic [NREQ-1:0]              r_in_ready,
  output logic [NREQ-1:0]              r_out_valid,
  output logic [DATA_OUT_BITS-1:0]     r_data_out,
  output logic                         core_force_reset,
  output logic [DATA_IN_BITS-1:0]      core_data_in,
  output logic                         core_in_valid,
  output logic                         core_in_last,
  output logic [LEN_W-1:0]             core_last_len,
  output logic                         core_out_ready,
  input  logic [DATA_OUT_BITS-1:0]     core_data_out,
  input  logic                         core_out_valid,
  input  logic                         core_in_ready
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  logic             owner_req;
  logic             connected;

  logic [DATA_IN_BITS-1:0] data_arr [NREQ];
  logic [LEN_W-1:0]        len_arr  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = r_data_in[i*DATA_IN_BITS +: DATA_IN_BITS];
    assign len_arr[i]  = r_last_len[i*LEN_W +: LEN_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  // A drop of the owner's request disconnects it in that same cycle
  assign owner_req = req[owner];
  assign connected = (state == BUSY) && owner_req;

  // Arbitration FSM: owner, grant and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner  <= pick_idx;
            grant  <= pick_onehot;
            rr_ptr <= IDX_W'(wrap_add(int'(pick_idx), 1, NREQ));
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          if (owner_req) begin
            state <= BUSY;
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Owner-indexed stream mux; everything blanked outside a live BUSY cycle
  always_comb begin
    core_force_reset = 1'b0;
    core_data_in     = '0;
    core_in_valid    = 1'b0;
    core_in_last     = 1'b0;
    core_last_len    = '0;
    core_out_ready   = 1'b0;
    r_in_ready       = '0;
    r_out_valid      = '0;
    r_data_out       = '0;
    if (state == FLUSH) begin
      core_force_reset = 1'b1;
    end else if (connected) begin
      core_force_reset   = r_force_reset[owner];
      core_data_in       = data_arr[owner];
      core_in_valid      = r_in_valid[owner];
      core_in_last       = r_in_last[owner];
      core_last_len      = len_arr[owner];
      core_out_ready     = r_out_ready[owner];
      r_in_ready[owner]  = core_in_ready;
      r_out_valid[owner] = core_out_valid;
      r_data_out         = core_data_out;
    end
  end

endmodule

// File: tb/tb_shake_arbiter.sv
// Scoreboard bench for shake_arbiter: stimulus pushes expected grants, flush
// owners, absorbed words and delivered squeeze words; a negedge monitor pops
// and compares whenever the DUT presents the corresponding event.
module tb_shake_arbiter;
  import dilithium_pkg::*;

  localparam int NREQ = 4;
  localparam int DIB  = 64;
  localparam int DOB  = 64;
  localparam int LW   = 7;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        grant;
  logic [NREQ-1:0]        r_force_reset;
  logic [NREQ*DIB-1:0]    r_data_in;
  logic [NREQ-1:0]        r_in_valid;
  logic [NREQ-1:0]        r_in_last;
  logic [NREQ*LW-1:0]     r_last_len;
  logic [NREQ-1:0]        r_out_ready;
  logic [NREQ-1:0]        r_in_ready;
  logic [NREQ-1:0]        r_out_valid;
  logic [DOB-1:0]         r_data_out;
  logic                   core_force_reset;
  logic [DIB-1:0]         core_data_in;
  logic                   core_in_valid;
  logic                   core_in_last;
  logic [LW-1:0]          core_last_len;
  logic                   core_out_ready;
  logic [DOB-1:0]         core_data_out;
  logic                   core_out_valid;
  logic                   core_in_ready;

  shake_arbiter #(
    .NREQ          (NREQ),
    .DATA_IN_BITS  (DIB),
    .DATA_OUT_BITS (DOB),
    .LEN_W         (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .grant            (grant),
    .r_force_reset    (r_force_reset),
    .r_data_in        (r_data_in),
    .r_in_valid       (r_in_valid),
    .r_in_last        (r_in_last),
    .r_last_len       (r_last_len),
    .r_out_ready      (r_out_ready),
    .r_in_ready       (r_in_ready),
    .r_out_valid      (r_out_valid),
    .r_data_out       (r_data_out),
    .core_force_reset (core_force_reset),
    .core_data_in     (core_data_in),
    .core_in_valid    (core_in_valid),
    .core_in_last     (core_in_last),
    .core_last_len    (core_last_len),
    .core_out_ready   (core_out_ready),
    .core_data_out    (core_data_out),
    .core_out_valid   (core_out_valid),
    .core_in_ready    (core_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] absorb_q  [$];
  logic [67:0] squeeze_q [$];
  logic [3:0]  grant_q   [$];
  logic [3:0]  flush_q   [$];
  logic [3:0]  prev_grant;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (grant !== prev_grant && grant != 4'b0000) begin
      if (grant_q.size() == 0) check("grant_unexpected", 72'(grant), 72'd0);
      else check("grant_order", 72'(grant), 72'(grant_q.pop_front()));
    end
    prev_grant <= grant;
    if (core_force_reset) begin
      if (flush_q.size() == 0) check("flush_unexpected", 72'(grant), 72'd0);
      else check("flush_owner", 72'(grant), 72'(flush_q.pop_front()));
    end
    if (core_in_valid && core_in_ready) begin
      if (absorb_q.size() == 0) check("absorb_unexpected", 72'(core_data_in), 72'd0);
      else check("absorb_word", 72'({core_in_last, core_data_in}), 72'(absorb_q.pop_front()));
    end
    if (core_out_valid && core_out_ready) begin
      if (squeeze_q.size() == 0) check("squeeze_unexpected", 72'(r_data_out), 72'd0);
      else check("squeeze_word", 72'({r_out_valid, r_data_out}), 72'(squeeze_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r_force_reset  = '0;
    r_data_in      = '0;
    r_in_valid     = '0;
    r_in_last      = '0;
    r_last_len     = '0;
    r_out_ready    = '0;
    core_out_valid = 1'b0;
    core_data_out  = '0;
  endtask

  task automatic expect_grant(input logic [3:0] m);
    grant_q.push_back(m);
    flush_q.push_back(m);
  endtask

  task automatic wait_grant(input logic [3:0] m, input string name);
    int n = 0;
    while (grant !== m && n < 8) begin
      tick();
      n++;
    end
    check(name, 72'(grant), 72'(m));
  endtask

  task automatic absorb(input int who, input logic [63:0] d, input logic last);
    r_in_valid[who]         = 1'b1;
    r_data_in[who*DIB +: DIB] = d;
    r_in_last[who]          = last;
    r_last_len[who*LW +: LW] = 7'd64;
    absorb_q.push_back({last, d});
    tick();
    r_in_valid[who] = 1'b0;
    r_in_last[who]  = 1'b0;
  endtask

  task automatic squeeze(input int who, input logic [63:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << who;
    core_out_valid   = 1'b1;
    core_data_out    = d;
    r_out_ready[who] = 1'b1;
    squeeze_q.push_back({oh, d});
    tick();
    core_out_valid   = 1'b0;
    r_out_ready[who] = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    clear_inputs();
    #2;
    check("reset_grant", 72'(grant), 72'd0);
    check("reset_core_ctrl", 72'({core_force_reset, core_in_valid, core_in_last, core_out_ready}), 72'd0);
    check("reset_r_ctrl", 72'({r_in_ready, r_out_valid}), 72'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    core_in_ready = 1'b1;
    apply_reset();

    // 1: single owner, full transaction
    tick();
    expect_grant(4'b0001);
    req = 4'b0001;
    tick();
    check("t1_grant", 72'(grant), 72'h1);
    check("t1_flush", 72'(core_force_reset), 72'h1);
    tick();
    check("t1_flush_once", 72'(core_force_reset), 72'h0);
    check("t1_in_ready", 72'(r_in_ready), 72'h1);
    absorb(0, 64'h0123_4567_89ab_cdef, 1'b0);
    absorb(0, 64'hfeed_face_cafe_f00d, 1'b1);
    squeeze(0, 64'ha5a5_5a5a_0f0f_f0f0);
    squeeze(0, 64'h1111_2222_3333_4444);
    r_in_valid[0]  = 1'b1;
    r_out_ready[0] = 1'b1;
    req = 4'b0000;
    #1;
    check("t1_release_gate", 72'({core_in_valid, core_out_ready}), 72'h0);
    check("t1_grant_held", 72'(grant), 72'h1);
    tick();
    clear_inputs();
    check("t1_grant_clear", 72'(grant), 72'h0);

    // 2: simultaneous requests from reset
    apply_reset();
    expect_grant(4'b0001);
    expect_grant(4'b0100);
    req = 4'b0101;
    wait_grant(4'b0001, "t2_first");
    tick();
    absorb(0, 64'h0000_0000_0000_0002, 1'b1);
    req = 4'b0100;
    tick();
    check("t2_gap", 72'(grant), 72'h0);
    tick();
    check("t2_second", 72'(grant), 72'h4);
    tick();
    absorb(2, 64'h2222_0000_0000_0002, 1'b1);
    req = 4'b0000;
    tick();

    // 3: all requesting, fair rotation
    apply_reset();
    expect_grant(4'b0001);
    expect_grant(4'b0010);
    expect_grant(4'b0100);
    expect_grant(4'b1000);
    expect_grant(4'b0001);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int who;
      who = g % 4;
      wait_grant(4'b0001 << who, "t3_grant");
      tick();
      for (int b = 0; b < 3; b++)
        absorb(who, {32'(g), 32'(b)} ^ 64'h3300_0000_0000_0000, b == 2);
      if (g < 4) begin
        req[who] = 1'b0;
        tick();
        req[who] = 1'b1;
      end
    end
    req = 4'b0000;
    tick();

    // 4: release while a squeeze word is pending
    expect_grant(4'b0010);
    req = 4'b0010;
    wait_grant(4'b0010, "t4_grant");
    tick();
    core_out_valid = 1'b1;
    core_data_out  = 64'hdead_beef_dead_beef;
    r_out_ready[1] = 1'b1;
    req = 4'b0000;
    #1;
    check("t4_out_ready_gated", 72'(core_out_ready), 72'h0);
    check("t4_out_valid_hidden", 72'(r_out_valid), 72'h0);
    tick();
    r_out_ready[1] = 1'b0;
    expect_grant(4'b0001);
    req = 4'b0001;
    r_out_ready[0] = 1'b1;
    tick();
    check("t4_flush", 72'(core_force_reset), 72'h1);
    check("t4_flush_blank", 72'({core_out_ready, r_out_valid}), 72'h0);
    core_out_valid = 1'b0;
    r_out_ready[0] = 1'b0;
    tick();

    // 5: non-owner activity during BUSY (owner 0)
    r_in_valid[2]       = 1'b1;
    r_force_reset[2]    = 1'b1;
    r_out_ready[2]      = 1'b1;
    r_data_in[2*DIB +: DIB] = 64'hbad0_bad0_bad0_bad0;
    core_out_valid      = 1'b1;
    #1;
    check("t5_in_valid", 72'(core_in_valid), 72'h0);
    check("t5_force_reset", 72'(core_force_reset), 72'h0);
    check("t5_out_ready", 72'(core_out_ready), 72'h0);
    check("t5_in_ready", 72'(r_in_ready), 72'h1);
    check("t5_out_valid", 72'(r_out_valid), 72'h1);
    absorb(0, 64'h5555_aaaa_5555_aaaa, 1'b1);
    clear_inputs();
    req = 4'b0000;
    tick();

    // 6: asynchronous reset mid-BUSY, then fresh start
    expect_grant(4'b0100);
    req = 4'b0100;
    wait_grant(4'b0100, "t6_grant");
    tick();
    r_in_valid[2]    = 1'b1;
    r_force_reset[2] = 1'b1;
    r_out_ready[2]   = 1'b1;
    core_out_valid   = 1'b1;
    core_data_out    = 64'h6666_0000_6666_0000;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", 72'(grant), 72'h0);
    check("t6_rst_core", 72'({core_force_reset, core_in_valid, core_out_ready}), 72'h0);
    check("t6_rst_r", 72'({r_in_ready, r_out_valid}), 72'h0);
    check("t6_rst_data", 72'(r_data_out), 72'h0);
    clear_inputs();
    req = 4'b0000;
    tick();
    tick();
    expect_grant(4'b0010);
    req   = 4'b0010;
    rst_n = 1'b1;
    wait_grant(4'b0010, "t6_after_reset");
    check("t6_flush", 72'(core_force_reset), 72'h1);
    tick();
    absorb(1, 64'h6060_6060_6060_6060, 1'b1);
    squeeze(1, 64'h0606_0606_0606_0606);
    req = 4'b0000;
    tick();
    tick();

    check("grant_q_drained", 72'(grant_q.size()), 72'd0);
    check("flush_q_drained", 72'(flush_q.size()), 72'd0);
    check("absorb_q_drained", 72'(absorb_q.size()), 72'd0);
    check("squeeze_q_drained", 72'(squeeze_q.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
